// File: rtl/mean_pkg.sv
// Shared types and defaults for the mean-sequencing controller.
package mean_pkg;

    localparam int unsigned ZonesDefault      = 8;
    localparam int unsigned PixPerZoneDefault = 65536;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAccum,
        StShift,
        StWaitDone,
        StPresent
    } state_e;

endpackage

// File: rtl/mean_zone_cnt.sv
// Pixel-within-zone and zone counters; last_o flags the final pixel of the final zone.
module mean_zone_cnt #(
    parameter int unsigned ZONES        = 8,
    parameter int unsigned PIX_PER_ZONE = 65536
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       inc_i,
    output logic [$clog2(ZONES)-1:0]   zone_o,
    output logic                       last_o
);

    localparam int unsigned ZW = $clog2(ZONES);
    localparam int unsigned PW = $clog2(PIX_PER_ZONE);

    localparam logic [PW-1:0] PixLast  = PW'(PIX_PER_ZONE - 1);
    localparam logic [ZW-1:0] ZoneLast = ZW'(ZONES - 1);

    logic [PW-1:0] pix_q, pix_d;
    logic [ZW-1:0] zone_q, zone_d;

    always_comb begin
        pix_d  = pix_q;
        zone_d = zone_q;
        if (clr_i) begin
            pix_d  = '0;
            zone_d = '0;
        end else if (inc_i) begin
            if (pix_q == PixLast) begin
                pix_d  = '0;
                zone_d = (zone_q == ZoneLast) ? '0 : zone_q + ZW'(1);
            end else begin
                pix_d = pix_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix_q  <= '0;
            zone_q <= '0;
        end else begin
            pix_q  <= pix_d;
            zone_q <= zone_d;
        end
    end

    assign zone_o = zone_q;
    assign last_o = (pix_q == PixLast) && (zone_q == ZoneLast);

endmodule

// File: rtl/mean_seq_ctrl.sv
// Frame sequencer: clear, per-zone accumulate, square/shift, present means downstream.
// Optional drop_cnt_o counter of ignored frame starts when MEAN_SEQ_DROP_CNT_EN is defined.
module mean_seq_ctrl
    import mean_pkg::*;
#(
    parameter int unsigned ZONES        = ZonesDefault,
    parameter int unsigned PIX_PER_ZONE = PixPerZoneDefault
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_start_i,
    input  logic                     pix_valid_i,
    output logic                     acc_clr_o,
    output logic                     acc_en_o,
    output logic [$clog2(ZONES)-1:0] acc_zone_o,
    output logic                     shift_start_o,
    input  logic                     shift_done_i,
    output logic                     mean_valid_o,
    input  logic                     mean_ready_i,
    output logic                     busy_o,
`ifdef MEAN_SEQ_DROP_CNT_EN
    output logic [7:0]               drop_cnt_o,
`endif
    output logic                     overrun_o
);

    state_e state_q, state_d;
    logic   overrun_q, overrun_d;
    logic   abort;
    logic   cnt_clr, cnt_inc, cnt_last;

    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        abort     = 1'b0;
        case (state_q)
            StIdle:     if (frame_start_i) state_d = StClear;
            StClear:    state_d = StAccum;
            StAccum: begin
                if (frame_start_i) begin
                    abort     = 1'b1;
                    overrun_d = 1'b1;
                    state_d   = StClear;
                end else if (pix_valid_i && cnt_last) begin
                    state_d = StShift;
                end
            end
            StShift:    state_d = StWaitDone;
            StWaitDone: if (shift_done_i) state_d = StPresent;
            StPresent:  if (mean_ready_i) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end

    // A pixel arriving alongside an abort is discarded with the frame.
    assign cnt_inc = (state_q == StAccum) && pix_valid_i && !frame_start_i;
    assign cnt_clr = (state_q == StClear) || abort;

    mean_zone_cnt #(
        .ZONES        (ZONES),
        .PIX_PER_ZONE (PIX_PER_ZONE)
    ) u_zone_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .zone_o (acc_zone_o),
        .last_o (cnt_last)
    );

    assign acc_clr_o     = (state_q == StClear);
    assign acc_en_o      = (state_q == StAccum) && pix_valid_i;
    assign shift_start_o = (state_q == StShift);
    assign mean_valid_o  = (state_q == StPresent);
    assign busy_o        = (state_q != StIdle);
    assign overrun_o     = overrun_q;

`ifdef MEAN_SEQ_DROP_CNT_EN
    logic       fs_drop;
    logic [7:0] drop_cnt_q;

    assign fs_drop = frame_start_i &&
                     (state_q inside {StClear, StShift, StWaitDone, StPresent});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 8'd0;
        end else if (fs_drop && (drop_cnt_q != 8'hff)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mean_seq_ctrl.sv
// Self-checking bench for mean_seq_ctrl (ZONES=8, PIX_PER_ZONE=4): vector table,
// directed frame sequences and randomized traffic against a frame-level model.
module tb_mean_seq_ctrl;

    localparam int unsigned ZONES = 8;
    localparam int unsigned PPZ   = 4;
    localparam int unsigned NPIX  = ZONES * PPZ;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start_i = 1'b0;
    logic       pix_valid_i = 1'b0;
    logic       shift_done_i = 1'b0;
    logic       mean_ready_i = 1'b0;
    logic       acc_clr_o, acc_en_o, shift_start_o, mean_valid_o, busy_o, overrun_o;
    logic [2:0] acc_zone_o;
`ifdef MEAN_SEQ_DROP_CNT_EN
    logic [7:0] drop_cnt_o;
`endif

    always #5 clk = ~clk;

    mean_seq_ctrl #(
        .ZONES        (ZONES),
        .PIX_PER_ZONE (PPZ)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start_i (frame_start_i),
        .pix_valid_i   (pix_valid_i),
        .acc_clr_o     (acc_clr_o),
        .acc_en_o      (acc_en_o),
        .acc_zone_o    (acc_zone_o),
        .shift_start_o (shift_start_o),
        .shift_done_i  (shift_done_i),
        .mean_valid_o  (mean_valid_o),
        .mean_ready_i  (mean_ready_i),
        .busy_o        (busy_o),
`ifdef MEAN_SEQ_DROP_CNT_EN
        .drop_cnt_o    (drop_cnt_o),
`endif
        .overrun_o     (overrun_o)
    );

    int checks = 0;
    int errors = 0;

    // Frame-level model: phase 0 idle, 1 clear, 2 accumulate, 3 shift, 4 wait, 5 present.
    int m_ph   = 0;
    int m_npix = 0;
    int m_drop = 0;
    int m_ovr  = 0;

    // Outputs captured by the last step
    int o_clr, o_en, o_zone, o_shift, o_valid, o_busy, o_ovr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_npix = 0; m_drop = 0; m_ovr = 0;
    endtask

    task automatic model_advance(input logic fs, input logic pv, input logic done,
                                 input logic rdy);
        bit dropped = 1'b0;
        case (m_ph)
            0: if (fs) m_ph = 1;
            1: begin dropped = fs; m_ph = 2; m_npix = 0; end
            2: begin
                if (fs) begin
                    m_ovr = 1; m_npix = 0; m_ph = 1;
                end else if (pv) begin
                    m_npix++;
                    if (m_npix == NPIX) begin m_npix = 0; m_ph = 3; end
                end
            end
            3: begin dropped = fs; m_ph = 4; end
            4: begin dropped = fs; if (done) m_ph = 5; end
            5: begin dropped = fs; if (rdy) m_ph = 0; end
            default: m_ph = 0;
        endcase
        if (dropped && m_drop < 255) m_drop++;
    endtask

    task automatic sample();
        o_clr = int'(acc_clr_o); o_en = int'(acc_en_o); o_zone = int'(acc_zone_o);
        o_shift = int'(shift_start_o); o_valid = int'(mean_valid_o);
        o_busy = int'(busy_o); o_ovr = int'(overrun_o);
    endtask

    task automatic check_model(input logic pv);
        chk("model_acc_clr", o_clr, int'(m_ph == 1));
        chk("model_acc_en", o_en, int'(m_ph == 2 && pv));
        chk("model_acc_zone", o_zone, m_npix / PPZ);
        chk("model_shift_start", o_shift, int'(m_ph == 3));
        chk("model_mean_valid", o_valid, int'(m_ph == 5));
        chk("model_busy", o_busy, int'(m_ph != 0));
        chk("model_overrun", o_ovr, m_ovr);
`ifdef MEAN_SEQ_DROP_CNT_EN
        chk("model_drop_cnt", int'(drop_cnt_o), m_drop);
`endif
    endtask

    task automatic step(input logic fs, input logic pv, input logic done, input logic rdy);
        @(negedge clk);
        frame_start_i = fs; pix_valid_i = pv; shift_done_i = done; mean_ready_i = rdy;
        #1;
        sample();
        check_model(pv);
        @(posedge clk);
        model_advance(fs, pv, done, rdy);
    endtask

    // Asserts reset mid-cycle with busy inputs and checks outputs fall at once.
    task automatic do_reset(input string tag);
        @(negedge clk);
        frame_start_i = 1'b0; pix_valid_i = 1'b1; shift_done_i = 1'b1; mean_ready_i = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        sample();
        chk({tag, "_clr"}, o_clr, 0);
        chk({tag, "_en"}, o_en, 0);
        chk({tag, "_zone"}, o_zone, 0);
        chk({tag, "_shift"}, o_shift, 0);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_ovr"}, o_ovr, 0);
`ifdef MEAN_SEQ_DROP_CNT_EN
        chk({tag, "_drop"}, int'(drop_cnt_o), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        frame_start_i = 1'b0; pix_valid_i = 1'b0; shift_done_i = 1'b0; mean_ready_i = 1'b0;
    endtask

    typedef struct {
        logic       fs, pv, done, rdy;
        logic       clr, en;
        logic [2:0] zone;
        logic       shift, valid, busy, ovr;
    } vec_t;

    vec_t vec[12];

    initial begin
        int n_clr, n_en, n_valid, prev_zone, prev_en, shift_at;

        // fs pv dn rdy | clr en zone shift valid busy ovr
        vec[0]  = '{0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0};
        vec[1]  = '{1, 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0};
        vec[2]  = '{0, 1, 0, 0, 1, 0, 3'd0, 0, 0, 1, 0};
        vec[3]  = '{0, 1, 0, 0, 0, 1, 3'd0, 0, 0, 1, 0};
        vec[4]  = '{0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 1, 0};
        vec[5]  = '{0, 1, 1, 0, 0, 1, 3'd0, 0, 0, 1, 0};
        vec[6]  = '{0, 1, 0, 1, 0, 1, 3'd0, 0, 0, 1, 0};
        vec[7]  = '{0, 1, 0, 0, 0, 1, 3'd0, 0, 0, 1, 0};
        vec[8]  = '{0, 1, 0, 0, 0, 1, 3'd1, 0, 0, 1, 0};
        vec[9]  = '{1, 0, 0, 0, 0, 0, 3'd1, 0, 0, 1, 0};
        vec[10] = '{0, 1, 0, 0, 1, 0, 3'd0, 0, 0, 1, 1};
        vec[11] = '{0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 1, 1};

        do_reset("reset");

        for (int i = 0; i < 12; i++) begin
            step(vec[i].fs, vec[i].pv, vec[i].done, vec[i].rdy);
            chk($sformatf("vec%0d_clr", i), o_clr, int'(vec[i].clr));
            chk($sformatf("vec%0d_en", i), o_en, int'(vec[i].en));
            chk($sformatf("vec%0d_zone", i), o_zone, int'(vec[i].zone));
            chk($sformatf("vec%0d_shift", i), o_shift, int'(vec[i].shift));
            chk($sformatf("vec%0d_valid", i), o_valid, int'(vec[i].valid));
            chk($sformatf("vec%0d_busy", i), o_busy, int'(vec[i].busy));
            chk($sformatf("vec%0d_ovr", i), o_ovr, int'(vec[i].ovr));
        end

        // Normal frame with continuous pixels, then shift/present handshake
        do_reset("reset_normal");
        n_clr = 0;
        step(1, 0, 0, 0); n_clr += o_clr;
        step(0, 1, 0, 0); n_clr += o_clr;
        for (int i = 0; i < int'(NPIX); i++) begin
            step(0, 1, 0, 0);
            n_clr += o_clr;
            chk("normal_en", o_en, 1);
            chk("normal_zone_step", o_zone, i / int'(PPZ));
        end
        step(0, 0, 0, 0); n_clr += o_clr;
        chk("normal_shift_after_last", o_shift, 1);
        chk("normal_zone_back_to_0", o_zone, 0);
        chk("normal_clr_pulses", n_clr, 1);
        step(0, 0, 0, 0);
        chk("normal_shift_one_cycle", o_shift, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        n_valid = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            n_valid += o_valid;
        end
        step(0, 0, 0, 1); n_valid += o_valid;
        chk("handshake_valid_cycles", n_valid, 6);
        step(0, 0, 0, 0);
        chk("handshake_valid_dropped", o_valid, 0);
        chk("handshake_busy_dropped", o_busy, 0);

        // Gapped pixels: pix_valid toggles
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        n_en = 0; prev_zone = 0; prev_en = 0;
        for (int i = 0; i < 2 * int'(NPIX); i++) begin
            step(0, logic'(i % 2), 0, 0);
            n_en += o_en;
            if (o_zone != prev_zone) chk("gap_zone_moves_on_accept", prev_en, 1);
            prev_zone = o_zone; prev_en = o_en;
        end
        chk("gap_en_count", n_en, int'(NPIX));
        step(0, 0, 0, 0);
        chk("gap_shift", o_shift, 1);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("gap_idle", o_busy, 0);

        // Abort at pixel 10, then a full frame completes
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        chk("abort_ovr_before", o_ovr, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("abort_clr_again", o_clr, 1);
        chk("abort_overrun", o_ovr, 1);
        shift_at = -1;
        for (int i = 0; i < int'(NPIX) + 1; i++) begin
            step(0, 1, 0, 0);
            if (o_shift == 1 && shift_at < 0) shift_at = i;
        end
        chk("abort_shift_after_32", shift_at, int'(NPIX));

        // Frame start in WAIT_DONE is dropped
        step(1, 0, 0, 0);
        chk("drop_wait_busy", o_busy, 1);
        step(0, 0, 0, 0);
        chk("drop_no_clr", o_clr, 0);
        chk("drop_still_waiting", o_valid, 0);
`ifdef MEAN_SEQ_DROP_CNT_EN
        chk("drop_cnt_one", int'(drop_cnt_o), 1);
`endif
        step(1, 0, 1, 1);
        step(1, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("drop_present_fs_idle", o_busy, 0);
        chk("overrun_sticky", o_ovr, 1);

        // Reset in ACCUM
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        do_reset("reset_in_accum");
        step(0, 1, 0, 0);
        chk("post_reset_idle", o_busy, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            step(logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mean_seq_ctrl.md
MEAN_SEQ_CTRL -- requirements
Module: mean_seq_ctrl

Interface
REQ-001 SHALL have parameter ZONES, default 8: number of zones accumulated per frame.
REQ-002 SHALL have parameter PIX_PER_ZONE, default 65536: pixels per zone; a power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port frame_start_i, input, 1 bit: one-cycle frame-start pulse.
REQ-006 SHALL have port pix_valid_i, input, 1 bit: pixel present on the accumulator input this cycle.
REQ-007 SHALL have port acc_clr_o, output, 1 bit: clears all zone sum registers.
REQ-008 SHALL have port acc_en_o, output, 1 bit: add the current pixel to zone acc_zone_o.
REQ-009 SHALL have port acc_zone_o, output, $clog2(ZONES) bits: zone currently being accumulated.
REQ-010 SHALL have port shift_start_o, output, 1 bit: drives start_i of the square/shift mean stage.
REQ-011 SHALL have port shift_done_i, input, 1 bit: start_o of the square/shift mean stage.
REQ-012 SHALL have port mean_valid_o, output, 1 bit: the MeanR/G/B bank is stable and valid.
REQ-013 SHALL have port mean_ready_i, input, 1 bit: the downstream LED driver has taken the means.
REQ-014 SHALL have port busy_o, output, 1 bit: state is not IDLE.
REQ-015 SHALL have port overrun_o, output, 1 bit: sticky; a frame was aborted mid-accumulation.

Function
REQ-016 SHALL implement states IDLE, CLEAR, ACCUM, SHIFT, WAIT_DONE, PRESENT.
REQ-017 IDLE -> CLEAR on frame_start_i; acc_clr_o SHALL be 1 for exactly the single CLEAR cycle, then the state SHALL move to ACCUM.
REQ-018 In ACCUM: acc_en_o = pix_valid_i (combinational); acc_en_o SHALL be 0 in every other state.
REQ-019 The pixel counter SHALL increment on each accepted pixel; at PIX_PER_ZONE-1 with pix_valid_i it SHALL wrap to 0 and acc_zone_o SHALL increment.
REQ-020 The accepted pixel that ends zone ZONES-1 SHALL move the state to SHIFT on the next cycle; acc_zone_o SHALL return to 0.
REQ-021 SHIFT SHALL assert shift_start_o for exactly one cycle, then go to WAIT_DONE.
REQ-022 WAIT_DONE SHALL go to PRESENT on the cycle shift_done_i=1; shift_done_i SHALL be ignored in all other states.
REQ-023 PRESENT SHALL hold mean_valid_o=1 until a cycle with mean_ready_i=1, then go to IDLE; mean_valid_o SHALL drop the following cycle.
REQ-024 frame_start_i in ACCUM SHALL abort the frame: overrun_o set, counters zeroed, next state CLEAR.
REQ-025 frame_start_i in CLEAR, SHIFT, WAIT_DONE or PRESENT SHALL be ignored (frame dropped).
REQ-026 frame_start_i with mean_ready_i in PRESENT SHALL complete the handshake and go to IDLE; the pulse SHALL be dropped.
REQ-027 overrun_o SHALL clear only on reset.

Reset
REQ-028 On rst_n=0, asynchronously: state IDLE, counters 0, overrun_o 0.
REQ-029 Reset values: acc_clr_o, acc_en_o, shift_start_o, mean_valid_o and busy_o 0; acc_zone_o 0.
REQ-030 Reset mid-operation SHALL abandon the frame with no pulse on any output.

Configuration
REQ-031 With MEAN_SEQ_DROP_CNT_EN defined: output drop_cnt_o, 8 bits, reset 0, SHALL increment, saturating at 255, on each frame_start_i ignored per REQ-025/026.
REQ-032 Without MEAN_SEQ_DROP_CNT_EN: no drop_cnt_o port and no counter logic.

Structure
REQ-033 Package mean_pkg SHALL hold the state enum and the ZONES/PIX_PER_ZONE defaults.
REQ-034 Sub-module mean_zone_cnt SHALL hold the pixel and zone counters, with inputs inc/clr and outputs zone/last.

Verification (PIX_PER_ZONE=4, ZONES=8)
REQ-035 Normal frame: frame_start, 32 continuous valid pixels -> one acc_clr_o pulse; acc_zone_o steps 0..7 every 4 pixels; one shift_start_o pulse one cycle after pixel 32.
REQ-036 Gapped pixels: 32 valid pixels with pix_valid_i toggling -> acc_en_o count equals 32; zone changes only on accepted pixels.
REQ-037 Handshake: shift_done_i 3 cycles after shift_start_o, mean_ready_i held 0 for 5 cycles -> mean_valid_o high 5+1 cycles; busy_o drops after ready.
REQ-038 Abort: frame_start at pixel 10 -> overrun_o=1; acc_clr_o pulses again; the next 32 pixels complete the frame normally.
REQ-039 Drop and reset: frame_start during WAIT_DONE -> ignored, drop_cnt_o=1 (macro on); rst_n low in ACCUM -> all outputs 0 immediately.
